csa_stream_accumulator: RTL

- Parametrised, sequential successor to the combinational 64-bit 3:2 carry-save adder.
- Accumulates a stream of WIDTH-bit unsigned operands in redundant sum/carry form, one 3:2 compression per accepted beat, with no carry propagation in the accumulate path.
- On the last beat of a frame it resolves the redundant pair with a chunked, multi-cycle carry-propagate add. It then presents the result on a valid/ready output.
- Sits behind Wallace-tree partial-product reduction and multi-operand summation paths as the final accumulate/resolve stage.

---
 rtl/csa_stream_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - carry-save stream accumulator with chunked carry-propagate resolve
// Optional overflow flag and out_ovf port: define CSA_ACC_OVF_EN.
module csa_stream_accumulator #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef CSA_ACC_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   u;
    logic [WIDTH-1:0]   v;
    logic [WIDTH-1:0]   maj;
    logic               c;
    logic [IDX_W-1:0]   chunk_idx;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               last_chunk;
    int                 lo;
    logic [CHUNK-1:0]   u_chunk;
    logic [CHUNK-1:0]   v_chunk;
    logic [CHUNK:0]     chunk_sum;
`ifdef CSA_ACC_OVF_EN
    logic               ovf_flag;
`endif

    assign in_ready   = (state == ACCUM);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign maj        = (u & v) | (v & in_data) | (in_data & u);
    assign last_chunk = (chunk_idx == IDX_W'(NCHUNK - 1));

    always_comb begin
        lo        = int'(chunk_idx) * CHUNK;
        u_chunk   = u[lo +: CHUNK];
        v_chunk   = v[lo +: CHUNK];
        chunk_sum = {1'b0, u_chunk} + {1'b0, v_chunk} + {{CHUNK{1'b0}}, c};
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && in_last) state_next = RESOLVE;
            RESOLVE: if (last_chunk) state_next = DONE;
            DONE:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            u         <= '0;
            v         <= '0;
            c         <= 1'b0;
            chunk_idx <= '0;
            count     <= '0;
            out_data  <= '0;
            out_count <= '0;
`ifdef CSA_ACC_OVF_EN
            ovf_flag  <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        // 3:2 compression; the carry vector's top bit falls off (mod 2^WIDTH)
                        u <= u ^ v ^ in_data;
                        v <= {maj[WIDTH-2:0], 1'b0};
                        if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
`ifdef CSA_ACC_OVF_EN
                        ovf_flag <= ovf_flag | maj[WIDTH-1];
`endif
                        if (in_last) begin
                            chunk_idx <= '0;
                            c         <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    out_data[lo +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    if (last_chunk) begin
                        chunk_idx <= '0;
                        c         <= 1'b0;
                        out_count <= count;
`ifdef CSA_ACC_OVF_EN
                        ovf_flag  <= ovf_flag | chunk_sum[CHUNK];
                        out_ovf   <= ovf_flag | chunk_sum[CHUNK];
`endif
                    end else begin
                        chunk_idx <= chunk_idx + IDX_W'(1);
                        c         <= chunk_sum[CHUNK];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        u     <= '0;
                        v     <= '0;
                        count <= '0;
`ifdef CSA_ACC_OVF_EN
                        ovf_flag <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
